chan_arb: RTL



---
 rtl/chan_arb_pkg.sv | 19 +
 rtl/chan_arb_rr_pick.sv | 55 +++++
 rtl/mux.sv | 25 ++
 rtl/chan_arb.sv | 119 +++++++++++
 4 files changed

// File: rtl/chan_arb_pkg.sv
// Shared types and helpers for the channel arbiter: state encoding and a
// constant-evaluable ceiling log2 used to size selects and counters.
package chan_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((1 << i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr,
// wrapping modulo NCHAN (rotate, priority-encode, un-rotate).
module chan_arb_rr_pick
  import chan_arb_pkg::*;
#(
  parameter int NCHAN = 4
) (
  input  logic [NCHAN-1:0]        eligible,
  input  logic [clog2(NCHAN)-1:0] ptr,
  output logic                    found,
  output logic [clog2(NCHAN)-1:0] idx
);

  localparam int SW = clog2(NCHAN);

  logic [NCHAN-1:0] rot_s;
  logic [SW-1:0]    off_s;

  // Rotate so ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    int j_v;
    int sum_v;
    j_v   = 0;
    sum_v = 0;
    rot_s = '0;
    found = 1'b0;
    off_s = '0;
    for (int k = 0; k < NCHAN; k++) begin
      j_v = int'(ptr) + k;
      if (j_v >= NCHAN) begin
        j_v = j_v - NCHAN;
      end else begin
        j_v = j_v;
      end
      rot_s[k] = eligible[j_v];
    end
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found = 1'b1;
        off_s = SW'(k);
      end else begin
        off_s = off_s;
      end
    end
    // Explicit wrap keeps non-power-of-two channel counts in range.
    sum_v = int'(ptr) + int'(off_s);
    if (sum_v >= NCHAN) begin
      sum_v = sum_v - NCHAN;
    end else begin
      sum_v = sum_v;
    end
    idx = SW'(sum_v);
  end

endmodule

// File: rtl/mux.sv
// Generic N-way word multiplexer; selects word sel out of SEL packed words.
module mux
  import chan_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEL   = 4
) (
  input  logic [SEL*WIDTH-1:0]  in_data,
  input  logic [clog2(SEL)-1:0] sel,
  output logic [WIDTH-1:0]      out_data
);

  // Word select; out-of-range selects yield zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < SEL; i++) begin
      if (sel == clog2(SEL)'(i)) begin
        out_data = in_data[i*WIDTH +: WIDTH];
      end else begin
        out_data = out_data;
      end
    end
  end

endmodule

// File: rtl/chan_arb.sv
// Round-robin burst arbiter sharing one downstream valid/ready word path among
// NCHAN channels, with a per-channel enable mask.
module chan_arb
  import chan_arb_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int WIDTH = 16,
  parameter int BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCHAN-1:0]        chan_en,
  input  logic [NCHAN-1:0]        in_valid,
  input  logic [NCHAN*WIDTH-1:0]  in_data,
  output logic [NCHAN-1:0]        in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [clog2(NCHAN)-1:0] out_chan,
  output logic                    busy
);

  localparam int SW = clog2(NCHAN);
  localparam int CW = clog2(BURST + 1);

  state_t        state_r, state_n;
  logic [SW-1:0] gnt_sel_r, gnt_sel_n;
  logic [SW-1:0] rr_ptr_r, rr_ptr_n;
  logic [CW-1:0] burst_cnt_r, burst_cnt_n;

  logic          found_s;
  logic [SW-1:0] pick_s;
  logic [SW-1:0] next_ptr_s;
  logic          xfer_s;
  logic          last_s;

  chan_arb_rr_pick #(.NCHAN(NCHAN)) u_pick (
    .eligible (in_valid & chan_en),
    .ptr      (rr_ptr_r),
    .found    (found_s),
    .idx      (pick_s)
  );

  mux #(.WIDTH(WIDTH), .SEL(NCHAN)) u_mux (
    .in_data  (in_data),
    .sel      (gnt_sel_r),
    .out_data (out_data)
  );

  // Handshake outputs are combinational from the registered grant so reset drops them at once.
  always_comb begin
    busy      = (state_r == ST_GRANT);
    out_chan  = gnt_sel_r;
    out_valid = busy & in_valid[gnt_sel_r] & chan_en[gnt_sel_r];
    xfer_s    = out_valid & out_ready;
    last_s    = (burst_cnt_r == CW'(BURST - 1));
    in_ready  = '0;
    if (xfer_s) begin
      in_ready[gnt_sel_r] = 1'b1;
    end else begin
      in_ready = '0;
    end
    next_ptr_s = (gnt_sel_r == SW'(NCHAN - 1)) ? '0 : gnt_sel_r + SW'(1);
  end

  // Next-state: grant on arbitration, release on last transfer or dry/disabled channel.
  always_comb begin
    state_n     = state_r;
    gnt_sel_n   = gnt_sel_r;
    rr_ptr_n    = rr_ptr_r;
    burst_cnt_n = burst_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          gnt_sel_n   = pick_s;
          burst_cnt_n = '0;
          state_n     = ST_GRANT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!out_valid) begin
          rr_ptr_n = next_ptr_s;
          state_n  = ST_IDLE;
        end else if (xfer_s) begin
          burst_cnt_n = burst_cnt_r + CW'(1);
          if (last_s) begin
            rr_ptr_n = next_ptr_s;
            state_n  = ST_IDLE;
          end else begin
            state_n = ST_GRANT;
          end
        end else begin
          state_n = ST_GRANT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gnt_sel_r   <= '0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_n;
      gnt_sel_r   <= gnt_sel_n;
      rr_ptr_r    <= rr_ptr_n;
      burst_cnt_r <= burst_cnt_n;
    end
  end

endmodule
